// File: rtl/vector_mem_arbiter.sv
// Round-robin arbiter/sequencer for one 512-bit vector per transaction on the shared vector memory port.
// Done pulses 2 cycles after the request-sampling edge (1 on range error); requesters hold *_req until done.
module vector_mem_arbiter #(
  parameter int ADDR_W = 9,
  parameter int VLEN   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_req,
  input  logic                 a_we,
  input  logic [ADDR_W-1:0]    a_addr,
  input  logic [32*VLEN-1:0]   a_wdata,
  output logic                 a_done,
  output logic                 a_err,
  input  logic                 b_req,
  input  logic                 b_we,
  input  logic [ADDR_W-1:0]    b_addr,
  input  logic [32*VLEN-1:0]   b_wdata,
  output logic                 b_done,
  output logic                 b_err,
  output logic [32*VLEN-1:0]   rdata,
  output logic                 busy,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [32*VLEN-1:0]   mem_wdata,
  output logic                 mem_we,
  input  logic [32*VLEN-1:0]   mem_rdata,
  output logic [15:0]          xfer_cnt
);

  localparam int DW = 32 * VLEN;
  localparam logic [ADDR_W:0] MAX_BASE = (ADDR_W+1)'((1 << ADDR_W) - VLEN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // ptr / lat_port: 0 selects port A, 1 selects port B
  logic ptr;
  logic lat_port;
  logic lat_we;
  logic lat_err;

  logic              any_req;
  logic              grant_b;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DW-1:0]     sel_wdata;
  logic              sel_err;

  always_comb begin
    any_req   = a_req | b_req;
    grant_b   = b_req & (~a_req | ptr);
    sel_we    = grant_b ? b_we    : a_we;
    sel_addr  = grant_b ? b_addr  : a_addr;
    sel_wdata = grant_b ? b_wdata : a_wdata;
    sel_err   = ({1'b0, sel_addr} > MAX_BASE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = sel_err ? DONE : ACCESS;
        end
      end
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Done/err are registered so they assert on the edge that enters DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= 1'b0;
      lat_port  <= 1'b0;
      lat_we    <= 1'b0;
      lat_err   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      a_done    <= 1'b0;
      b_done    <= 1'b0;
      a_err     <= 1'b0;
      b_err     <= 1'b0;
      rdata     <= '0;
      xfer_cnt  <= '0;
    end else begin
      mem_we <= 1'b0;
      a_done <= 1'b0;
      b_done <= 1'b0;
      a_err  <= 1'b0;
      b_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            lat_port  <= grant_b;
            lat_we    <= sel_we;
            lat_err   <= sel_err;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            if (sel_err) begin
              a_done <= ~grant_b;
              b_done <= grant_b;
              a_err  <= ~grant_b;
              b_err  <= grant_b;
            end else begin
              mem_we <= sel_we;
            end
          end
        end
        ACCESS: begin
          if (!lat_we) begin
            rdata <= mem_rdata;
          end
          a_done <= ~lat_port;
          b_done <= lat_port;
        end
        DONE: begin
          ptr <= ~lat_port;
          if (!lat_err) begin
            xfer_cnt <= xfer_cnt + 16'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_mem_arbiter.sv
// Randomized and directed bench for vector_mem_arbiter with a memory array and transaction-level reference model.
module tb_vector_mem_arbiter;

  localparam int AW = 9;
  localparam int VL = 16;
  localparam int DW = 32 * VL;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req, b_req, a_we, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_done, b_done, a_err, b_err, busy, mem_we;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [15:0]   xfer_cnt;

  logic [31:0] mem     [512];
  logic [31:0] ref_mem [512];

  int n_checks = 0;
  int n_fail   = 0;
  int we_total = 0;

  logic [15:0]   exp_cnt;
  logic [DW-1:0] exp_rdata;
  logic [DW-1:0] pat, vec_tmp;
  logic [31:0]   save495;
  bit            r_port, r_we;
  logic [AW-1:0] r_addr;
  int            cyc, last, ndone, lat;

  always #5 clk = ~clk;

  vector_mem_arbiter #(.ADDR_W(AW), .VLEN(VL)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_done(a_done), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_done(b_done), .b_err(b_err),
    .rdata(rdata), .busy(busy), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .xfer_cnt(xfer_cnt)
  );

  always_comb begin
    for (int i = 0; i < VL; i++) mem_rdata[32*i +: 32] = mem[9'(mem_addr + 9'(i))];
  end

  always @(posedge clk) begin
    if (mem_we) for (int i = 0; i < VL; i++) mem[9'(mem_addr + 9'(i))] <= mem_wdata[32*i +: 32];
  end

  always @(negedge clk) if (mem_we) we_total <= we_total + 1;

  function automatic logic [DW-1:0] ref_vec(input int base);
    logic [DW-1:0] v;
    for (int i = 0; i < VL; i++) v[32*i +: 32] = ref_mem[base + i];
    return v;
  endfunction

  function automatic logic [DW-1:0] mem_vec(input int base);
    logic [DW-1:0] v;
    for (int i = 0; i < VL; i++) v[32*i +: 32] = mem[base + i];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One single-port transaction; the model predicts latency, flags, data and counter.
  task automatic txn(input bit port, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bit ok;
    int n, we0;
    ok = (int'(addr) <= 512 - VL);
    @(negedge clk);
    if (port) begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = data;
    end else begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = data;
    end
    we0 = we_total;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!a_done && !b_done && n < 8);
    if (ok) begin
      exp_cnt = exp_cnt + 16'd1;
      if (we) for (int i = 0; i < VL; i++) ref_mem[int'(addr) + i] = data[32*i +: 32];
      else exp_rdata = ref_vec(int'(addr));
    end
    chk_i("latency", n, ok ? 2 : 1);
    chk_i("done_port", int'({a_done, b_done}), port ? 1 : 2);
    chk_i("err_flags", int'({a_err, b_err}), ok ? 0 : (port ? 1 : 2));
    chk("rdata", rdata, exp_rdata);
    chk_i("mem_addr_hold", int'(mem_addr), int'(addr));
    chk_i("busy_in_done", int'(busy), 1);
    @(negedge clk);
    a_req = 1'b0; b_req = 1'b0;
    chk_i("we_cycles", we_total - we0, (ok && we) ? 1 : 0);
    @(posedge clk); #1;
    chk_i("xfer_cnt", int'(xfer_cnt), int'(exp_cnt));
    chk_i("busy_idle", int'(busy), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    a_req = 1'b0; b_req = 1'b0; a_we = 1'b0; b_we = 1'b0;
    a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
    exp_cnt = '0; exp_rdata = '0;
    for (int i = 0; i < 512; i++) begin
      ref_mem[i] = (i >= 100 && i <= 115) ? 32'(i) : $urandom;
      mem[i] = ref_mem[i];
    end
    #22;
    chk_i("rst_a_done", int'(a_done), 0);
    chk_i("rst_b_done", int'(b_done), 0);
    chk_i("rst_a_err", int'(a_err), 0);
    chk_i("rst_b_err", int'(b_err), 0);
    chk_i("rst_busy", int'(busy), 0);
    chk_i("rst_mem_we", int'(mem_we), 0);
    chk_i("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_rdata", rdata, '0);
    chk_i("rst_xfer_cnt", int'(xfer_cnt), 0);

    // Contention: both ports load continuously from reset release.
    a_req = 1'b1; a_we = 1'b0; a_addr = 9'd100;
    b_req = 1'b1; b_we = 1'b0; b_addr = 9'd200;
    @(negedge clk);
    rst = 1'b0;
    cyc = 0; last = 0; ndone = 0;
    while (ndone < 6 && cyc < 40) begin
      @(posedge clk); #1; cyc++;
      chk_i("both_done", int'(a_done & b_done), 0);
      if (a_done || b_done) begin
        chk_i("rr_order", int'(b_done), ndone % 2);
        chk("rr_rdata", rdata, ref_vec((ndone % 2 == 1) ? 200 : 100));
        chk_i("rr_interval", cyc - last, (ndone == 0) ? 2 : 3);
        last = cyc;
        ndone++;
      end
    end
    chk_i("rr_completions", ndone, 6);
    @(negedge clk);
    a_req = 1'b0; b_req = 1'b0;
    @(posedge clk); #1;
    exp_cnt = 16'd6;
    exp_rdata = ref_vec(200);
    chk_i("rr_xfer_cnt", int'(xfer_cnt), 6);

    // Single load on A.
    txn(1'b0, 1'b0, 9'd100, '0);
    chk_i("load_w0", int'(rdata[31:0]), 100);
    vec_tmp = rdata;
    chk_i("load_w15", int'(vec_tmp[511:480]), 115);

    // Store then load at the top valid base on B.
    for (int i = 0; i < VL; i++) pat[32*i +: 32] = 32'hA5A5_0000 + 32'(i);
    save495 = mem[495];
    txn(1'b1, 1'b1, 9'd496, pat);
    txn(1'b1, 1'b0, 9'd496, '0);
    chk("store_load_496", rdata, pat);
    chk_i("mem495_intact", int'(mem[495]), int'(save495));

    // Range errors: store and loads just past the boundary.
    txn(1'b0, 1'b1, 9'd497, pat);
    txn(1'b1, 1'b0, 9'd511, '0);
    txn(1'b0, 1'b0, 9'd500, '0);
    chk("err_rdata_unchanged", rdata, pat);

    // Store immediately followed by an overlapping load from the other port.
    for (int i = 0; i < VL; i++) pat[32*i +: 32] = $urandom;
    txn(1'b0, 1'b1, 9'd300, pat);
    txn(1'b1, 1'b0, 9'd305, '0);

    // Random single-port traffic, biased toward the range boundary.
    for (int t = 0; t < 40; t++) begin
      r_port = 1'($urandom_range(0, 1));
      r_we   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) r_addr = 9'($urandom_range(490, 511));
      else r_addr = 9'($urandom_range(0, 511));
      for (int i = 0; i < VL; i++) pat[32*i +: 32] = $urandom;
      txn(r_port, r_we, r_addr, pat);
    end

    // Reset in the middle of a store's ACCESS cycle.
    for (int i = 0; i < VL; i++) pat[32*i +: 32] = $urandom;
    vec_tmp = ref_vec(50);
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b1; a_addr = 9'd50; a_wdata = pat;
    @(posedge clk); #1;
    chk_i("access_mem_we", int'(mem_we), 1);
    chk_i("access_busy", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk_i("mid_rst_mem_we", int'(mem_we), 0);
    chk_i("mid_rst_busy", int'(busy), 0);
    chk_i("mid_rst_mem_addr", int'(mem_addr), 0);
    chk("mid_rst_mem_wdata", mem_wdata, '0);
    chk("mid_rst_rdata", rdata, '0);
    chk_i("mid_rst_xfer_cnt", int'(xfer_cnt), 0);
    @(posedge clk); #1;
    chk_i("mid_rst_no_done", int'({a_done, a_err}), 0);
    chk("mid_rst_no_commit", mem_vec(50), vec_tmp);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = '0;
    exp_rdata = '0;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!a_done && lat < 8);
    chk_i("rerequest_latency", lat, 2);
    chk_i("rerequest_err", int'(a_err), 0);
    for (int i = 0; i < VL; i++) ref_mem[50 + i] = pat[32*i +: 32];
    exp_cnt = 16'd1;
    @(negedge clk);
    a_req = 1'b0;
    @(posedge clk); #1;
    chk_i("rerequest_cnt", int'(xfer_cnt), 1);
    chk("rerequest_mem", mem_vec(50), ref_vec(50));

    // Counter wrap from 65535.
    @(negedge clk);
    force dut.xfer_cnt = 16'hFFFF;
    #1 release dut.xfer_cnt;
    exp_cnt = 16'hFFFF;
    txn(1'b1, 1'b1, 9'd496, pat);
    chk_i("cnt_wrap_zero", int'(xfer_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
